// File: rtl/trig_pkg.sv
// Shared definitions for the trigger-side histogram readout logic.
package trig_pkg;

  localparam int unsigned NHIST_DEF    = 8;
  localparam int unsigned BYTES_PER_CH = 4 * NHIST_DEF;
  localparam int unsigned SETTLE_DEF   = 3;
  localparam int unsigned CLR_HOLD_DEF = 3;
  localparam int unsigned CLR_GAP_DEF  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StCapture,
    StSend,
    StClear,
    StNext,
    StDone
  } hseq_state_t;

endpackage

// File: rtl/histo_byte_ser.sv
// Shadows one channel's histogram words and streams them as little-endian bytes
// over valid/ready, word 0 first.
module histo_byte_ser
  import trig_pkg::*;
#(
  parameter int unsigned NHIST  = NHIST_DEF,
  parameter int unsigned NBYTES = BYTES_PER_CH
) (
  input  logic                  clk_adc,
  input  logic                  nrst,
  input  logic                  load,
  input  logic [NHIST*32-1:0]   words,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic                  last_byte
);

  localparam int unsigned IW = $clog2(NBYTES);

  logic [NHIST*32-1:0] shadow_q;
  logic [IW-1:0]       idx_q;
  logic                valid_q;
  logic                xfer;

  assign xfer      = valid_q && out_ready;
  assign last_byte = xfer && (idx_q == IW'(NBYTES - 1));
  assign out_valid = valid_q;
  assign out_data  = valid_q ? shadow_q[8*idx_q +: 8] : 8'h00;

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      shadow_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
    end else if (load) begin
      shadow_q <= words;
      idx_q    <= '0;
      valid_q  <= 1'b1;
    end else if (xfer) begin
      if (last_byte) begin
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/histo_readout_sequencer.sv
// Scans a channel range: select, settle, capture, stream 32 bytes, optionally clear,
// then advance. Owns the histogram select and clear lines in the clk_adc domain.
module histo_readout_sequencer
  import trig_pkg::*;
#(
  parameter int unsigned NCH      = 64,
  parameter int unsigned NHIST    = NHIST_DEF,
  parameter int unsigned SETTLE   = SETTLE_DEF,
  parameter int unsigned CLR_HOLD = CLR_HOLD_DEF,
  parameter int unsigned CLR_GAP  = CLR_GAP_DEF
) (
  input  logic                clk_adc,
  input  logic                nrst,
  input  logic                start,
  input  logic [7:0]          first_ch,
  input  logic [7:0]          last_ch,
  input  logic                clear_after,
  input  logic [NHIST*32-1:0] histosin,
  output logic [7:0]          histostosend,
  output logic                resethist,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  hseq_state_t state_q, state_d;
  logic [7:0]  ch_q, ch_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        clr_q, clr_d;
  logic        err_q, err_d;
  logic        load;
  logic        last_byte;
  logic        range_bad;

  assign range_bad = (first_ch > last_ch) || (32'(last_ch) >= NCH);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = StSelect;
            ch_d    = first_ch;
            last_d  = last_ch;
            clr_d   = clear_after;
            cnt_d   = '0;
          end
        end
      end
      StSelect: begin
        if (cnt_q == 8'(SETTLE - 1)) state_d = StCapture;
        else                         cnt_d   = cnt_q + 8'd1;
      end
      StCapture: begin
        load    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (last_byte) begin
          cnt_d   = '0;
          state_d = clr_q ? StClear : StNext;
        end
      end
      // Clear pulse then a quiet gap; the select stays put for the whole window.
      StClear: begin
        if (cnt_q == 8'(CLR_HOLD + CLR_GAP - 1)) state_d = StNext;
        else                                     cnt_d   = cnt_q + 8'd1;
      end
      StNext: begin
        if (ch_q == last_q) begin
          state_d = StDone;
        end else begin
          ch_d    = ch_q + 8'd1;
          cnt_d   = '0;
          state_d = StSelect;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
    end
  end

  assign histostosend = ch_q;
  assign resethist    = (state_q == StClear) && (cnt_q < 8'(CLR_HOLD));
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign done         = (state_q == StDone);
  assign err          = err_q;

  histo_byte_ser #(
    .NHIST  (NHIST),
    .NBYTES (4 * NHIST)
  ) u_ser (
    .clk_adc   (clk_adc),
    .nrst      (nrst),
    .load      (load),
    .words     (histosin),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .last_byte (last_byte)
  );

endmodule
